// File: rtl/keypad_event_encoder.sv
// Scans a 4x4 active-low keypad, debounces it and emits one rec_num/rec_op pulse per accepted key.
// Latency: 2 sync + <=4*SCAN_DIV scan + DEBOUNCE_CYCLES + 1 clk from stable press to pulse.
// No backpressure: pulses are fire-and-forget, spaced by at least DEBOUNCE_CYCLES idle cycles.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat of held digit keys every REPEAT_CYCLES).
module keypad_event_encoder #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       rec_num,
    output logic       rec_op,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int SCAN_W = $clog2(SCAN_DIV) + 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

    state_t              state;
    logic [3:0]          rs_meta;
    logic [3:0]          rs;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [DEB_W-1:0]    deb_cnt;
    logic [1:0]          row;
    logic [1:0]          col;
    logic                row_lvl;
    logic [3:0]          emit_code;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES) + 1;
    logic [REP_W-1:0]    rep_cnt;
`endif

    // Keypad legend: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'd1;   4'h1: code = 4'd2;   4'h2: code = 4'd3;   4'h3: code = 4'd10;
            4'h4: code = 4'd4;   4'h5: code = 4'd5;   4'h6: code = 4'd6;   4'h7: code = 4'd11;
            4'h8: code = 4'd7;   4'h9: code = 4'd8;   4'hA: code = 4'd9;   4'hB: code = 4'd12;
            4'hC: code = 4'd15;  4'hD: code = 4'd0;   4'hE: code = 4'd14;  default: code = 4'd13;
        endcase
        return code;
    endfunction

    // Lowest-index low row wins when several rows read low at once.
    function automatic logic [1:0] lowest_low(input logic [3:0] v);
        logic [1:0] idx;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    assign row_lvl   = rs[row];
    assign emit_code = key_map(row, col);

    // Two-flop synchroniser for the asynchronous row inputs; idle level is all-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_meta <= 4'hF;
            rs      <= 4'hF;
        end else begin
            rs_meta <= row_n;
            rs      <= rs_meta;
        end
    end

    // Scan / debounce / emit / wait-for-release state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SCAN;
            scan_cnt <= '0;
            deb_cnt  <= '0;
            row      <= 2'd0;
            col      <= 2'd0;
            col_n    <= 4'b1110;
            rec_num  <= 1'b0;
            rec_op   <= 1'b0;
            key_code <= 4'd0;
            key_held <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt  <= '0;
`endif
        end else begin
            rec_num <= 1'b0;
            rec_op  <= 1'b0;
            case (state)
                SCAN: begin
                    if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                        scan_cnt <= '0;
                        if (rs != 4'hF) begin
                            // Column stays frozen on the one that produced the hit.
                            row     <= lowest_low(rs);
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col   <= col + 2'd1;
                            col_n <= {col_n[2:0], col_n[3]};
                        end
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (row_lvl) begin
                        // Bounce: resume scanning the same column from a fresh period.
                        deb_cnt  <= '0;
                        scan_cnt <= '0;
                        state    <= SCAN;
                    end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb_cnt  <= '0;
                        key_code <= emit_code;
                        if (emit_code < 4'd10) rec_num <= 1'b1;
                        else                   rec_op  <= 1'b1;
                        state    <= EMIT;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    key_held <= 1'b1;
                    deb_cnt  <= '0;
                    state    <= WAIT_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                    // The EMIT cycle itself counts as the first cycle of the repeat period.
                    rep_cnt  <= REP_W'(1);
`endif
                end
                WAIT_RELEASE: begin
                    if (row_lvl) begin
                        if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                            deb_cnt  <= '0;
                            key_held <= 1'b0;
                            scan_cnt <= '0;
                            col      <= col + 2'd1;
                            col_n    <= {col_n[2:0], col_n[3]};
                            state    <= SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        deb_cnt <= '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    // Only digits auto-repeat; any high cycle on the row restarts the period.
                    if (row_lvl) begin
                        rep_cnt <= '0;
                    end else if (key_code < 4'd10) begin
                        if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
                            rep_cnt <= '0;
                            rec_num <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
`endif
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Directed bench for keypad_event_encoder with a behavioural 4x4 keypad model.
// Key-map table is applied in a loop; bounce, rollover, reset and repeat are hand sequences.
// Pulses are observed on the falling clock edge.
module tb_keypad_event_encoder;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int REP      = 32;
    localparam int MAX_LAT  = 2 + 4 * SCAN_DIV + DEB + 1;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_REP  = 3;
`else
    localparam int EXP_REP  = 0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       rec_num;
    logic       rec_op;
    logic [3:0] key_code;
    logic       key_held;

    // keypad model: two independent keys
    logic       ka_en, kb_en;
    logic [1:0] ka_r, ka_c, kb_r, kb_c;

    int total, passed;
    int num_cnt, op_cnt, both_cnt;

    typedef struct {
        logic [1:0] r;
        logic [1:0] c;
        int         code;
        int         is_num;
    } vec_t;

    vec_t tbl[16];

    keypad_event_encoder #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .rec_num  (rec_num),
        .rec_op   (rec_op),
        .key_code (key_code),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row_n = 4'hF;
        if (ka_en && !col_n[ka_c]) row_n[ka_r] = 1'b0;
        if (kb_en && !col_n[kb_c]) row_n[kb_r] = 1'b0;
    end

    always @(negedge clk) begin
        if (rec_num) num_cnt++;
        if (rec_op) op_cnt++;
        if (rec_num && rec_op) both_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic check_le(input string nm, input int act, input int max);
        total++;
        if (act >= 1 && act <= max) passed++;
        else $display("FAIL %s: got %0d, required 1..%0d", nm, act, max);
    endtask

    task automatic wait_pulse(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(rec_num || rec_op) && lat < 300);
        if (!(rec_num || rec_op)) lat = 999;
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (key_held && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic int pulses();
        return num_cnt + op_cnt;
    endfunction

    // Full press / hold / release cycle for one key with its expected code.
    task automatic press_check(input vec_t v, input string nm);
        int         lat, n, base;
        logic [3:0] exp_col, exp_next;
        logic [1:0] nc;
        exp_col  = 4'b1111 ^ (4'b0001 << v.c);
        nc       = v.c + 2'd1;
        exp_next = 4'b1111 ^ (4'b0001 << nc);
        ka_r = v.r;
        ka_c = v.c;
        #1 base = pulses();
        ka_en = 1'b1;
        wait_pulse(lat);
        check_le({nm, " latency"}, lat, MAX_LAT);
        check({nm, " key_code"}, int'(key_code), v.code);
        check({nm, " rec_num"}, int'(rec_num), v.is_num);
        check({nm, " rec_op"}, int'(rec_op), 1 - v.is_num);
        @(negedge clk);
        check({nm, " pulse_width"}, int'(rec_num | rec_op), 0);
        repeat (20) @(negedge clk);
        check({nm, " key_held"}, int'(key_held), 1);
        check({nm, " col_frozen"}, int'(col_n), int'(exp_col));
        #1 check({nm, " one_pulse"}, pulses() - base, 1);
        ka_en = 1'b0;
        wait_release(n);
        check({nm, " release_lat"}, n, DEB + 2);
        check({nm, " next_col"}, int'(col_n), int'(exp_next));
    endtask

    initial begin
        int         lat, n, base, run;
        int         offs[$];
        vec_t       v;

        total = 0; passed = 0;
        num_cnt = 0; op_cnt = 0; both_cnt = 0;
        ka_en = 1'b0; kb_en = 1'b0;
        ka_r = 2'd0; ka_c = 2'd0; kb_r = 2'd0; kb_c = 2'd0;

        tbl[0]  = '{2'd0, 2'd0, 1, 1};   tbl[1]  = '{2'd0, 2'd1, 2, 1};
        tbl[2]  = '{2'd0, 2'd2, 3, 1};   tbl[3]  = '{2'd0, 2'd3, 10, 0};
        tbl[4]  = '{2'd1, 2'd0, 4, 1};   tbl[5]  = '{2'd1, 2'd1, 5, 1};
        tbl[6]  = '{2'd1, 2'd2, 6, 1};   tbl[7]  = '{2'd1, 2'd3, 11, 0};
        tbl[8]  = '{2'd2, 2'd0, 7, 1};   tbl[9]  = '{2'd2, 2'd1, 8, 1};
        tbl[10] = '{2'd2, 2'd2, 9, 1};   tbl[11] = '{2'd2, 2'd3, 12, 0};
        tbl[12] = '{2'd3, 2'd0, 15, 0};  tbl[13] = '{2'd3, 2'd1, 0, 1};
        tbl[14] = '{2'd3, 2'd2, 14, 0};  tbl[15] = '{2'd3, 2'd3, 13, 0};

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst col_n", int'(col_n), 14);
        check("rst rec_num", int'(rec_num), 0);
        check("rst rec_op", int'(rec_op), 0);
        check("rst key_code", int'(key_code), 0);
        check("rst key_held", int'(key_held), 0);

        // idle scan: each column held SCAN_DIV cycles, wrapping
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [1:0] ec;
            ec = 2'((i / SCAN_DIV) % 4);
            check($sformatf("scan col_n[%0d]", i), int'(col_n), int'(4'b1111 ^ (4'b0001 << ec)));
            @(negedge clk);
        end
        #1 check("idle no pulses", pulses(), 0);

        // every key of the matrix
        for (int i = 0; i < 16; i++)
            press_check(tbl[i], $sformatf("key[%0d]", tbl[i].code));

        // 'A' then '#': operator pulses only
        #1 base = num_cnt;
        press_check(tbl[3], "seqA");
        press_check(tbl[14], "seqHash");
        #1 check("A/# no rec_num", num_cnt - base, 0);

        // bounce on '3' then hold stable
        ka_r = 2'd0; ka_c = 2'd2;
        #1 base = pulses();
        for (int i = 0; i < 40; i++) begin
            ka_en = ((i / 3) % 2 == 0);
            @(negedge clk);
        end
        ka_en = 1'b0;
        #1 check("bounce no pulse", pulses() - base, 0);
        press_check(tbl[2], "bounce3");

        // hold '7', press '9' during WAIT_RELEASE
        ka_r = 2'd2; ka_c = 2'd0;
        #1 base = pulses();
        ka_en = 1'b1;
        wait_pulse(lat);
        check("hold7 code", int'(key_code), 7);
        kb_r = 2'd2; kb_c = 2'd2; kb_en = 1'b1;
        repeat (30) @(negedge clk);
        #1 check("rollover ignored", pulses() - base, 1);
        check("rollover code", int'(key_code), 7);
        check("rollover held", int'(key_held), 1);
        ka_en = 1'b0; kb_en = 1'b0;
        wait_release(n);
        check("rollover release", int'(key_held), 0);

        // press '8', reset during its debounce (column stuck beyond one scan period)
        ka_r = 2'd2; ka_c = 2'd1;
        ka_en = 1'b1;
        run = 0; n = 0;
        while (run < 6 && n < 100) begin
            @(negedge clk);
            n++;
            run = (col_n == 4'b1101) ? run + 1 : 0;
        end
        check("debounce8 reached", run, 6);
        #1 check("no pulse before rst", pulses() - base, 1);
        rst = 1'b1;
        #1;
        check("midrst col_n", int'(col_n), 14);
        check("midrst key_held", int'(key_held), 0);
        check("midrst rec_num", int'(rec_num), 0);
        check("midrst key_code", int'(key_code), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 base = pulses();
        wait_pulse(lat);
        check_le("post_rst latency", lat, MAX_LAT);
        check("post_rst code", int'(key_code), 8);
        check("post_rst rec_num", int'(rec_num), 1);
        repeat (60) @(negedge clk);
        #1 check("post_rst once", pulses() - base, 1);
        ka_en = 1'b0;
        wait_release(n);
        check("post_rst release", n, DEB + 2);

        // hold '0' well past EMIT: repeats only when auto-repeat is built in
        ka_r = 2'd3; ka_c = 2'd1;
        ka_en = 1'b1;
        wait_pulse(lat);
        check("rep0 code", int'(key_code), 0);
        offs.delete();
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (rec_num) offs.push_back(k);
        end
        check("rep0 count", offs.size(), EXP_REP);
        for (int i = 0; i < EXP_REP; i++)
            check($sformatf("rep0 offset[%0d]", i), (i < offs.size()) ? offs[i] : -1, (i + 1) * REP);
        check("rep0 code held", int'(key_code), 0);
        ka_en = 1'b0;
        wait_release(n);
        check("rep0 release", n, DEB + 2);

        // hold 'D': operators never repeat
        ka_r = 2'd3; ka_c = 2'd3;
        ka_en = 1'b1;
        wait_pulse(lat);
        check("repD code", int'(key_code), 13);
        #1 base = pulses();
        repeat (120) @(negedge clk);
        #1 check("repD no repeat", pulses() - base, 0);
        ka_en = 1'b0;
        wait_release(n);
        check("repD release", n, DEB + 2);

        check("never both pulses", both_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
